// File: rtl/mem_wb_stage.sv
// MEM stage of the 64-bit RISC-V pipeline: branch resolution, byte-addressed
// data memory with multi-cycle access, and the MEM/WB pipeline register.
module mem_wb_stage #(
   parameter int unsigned MEM_BYTES = 1024,
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned MEM_LAT   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        RegWrite_in,
   input  logic        MemtoReg_in,
   input  logic        Branch_in,
   input  logic        Zero_in,
   input  logic        Is_Greater_in,
   input  logic        MemWrite_in,
   input  logic        MemRead_in,
   input  logic [63:0] PCplusimm_in,
   input  logic [63:0] ALU_result_in,
   input  logic [63:0] WriteData_in,
   input  logic [3:0]  funct_in,
   input  logic [4:0]  rd_in,
   output logic        PCSrc,
   output logic [63:0] Branch_target,
   output logic        Flush,
   output logic        Stall,
   output logic        RegWrite_wb,
   output logic        MemtoReg_wb,
   output logic [63:0] ReadData_wb,
   output logic [63:0] ALU_result_wb,
   output logic [4:0]  rd_wb
);

   localparam logic [2:0] LAST_CNT = 3'(MEM_LAT - 1);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              complete_c;
   logic              store_en_c;
   logic [3:0]        nbytes_c;
   logic [ADDR_W-1:0] addr_c;
   logic [63:0]       raw_c;
   logic [63:0]       load_c;
   logic [2:0]        funct3;
   logic              cond_c;
   logic              unused_funct7;

   logic [7:0]        mem_q [MEM_BYTES];

   logic              regwrite_q;
   logic              memtoreg_q;
   logic [63:0]       readdata_q;
   logic [63:0]       aluresult_q;
   logic [4:0]        rd_q;

   assign funct3        = funct_in[2:0];
   assign unused_funct7 = funct_in[3];
   assign addr_c        = ALU_result_in[ADDR_W-1:0];

   // Branch condition from funct3; independent of the memory FSM
   always_comb begin
      cond_c = 1'b0;
      case (funct3)
         3'b000:  cond_c = Zero_in;
         3'b001:  cond_c = !Zero_in;
         3'b100:  cond_c = !Is_Greater_in && !Zero_in;
         3'b101:  cond_c = Is_Greater_in || Zero_in;
         default: cond_c = 1'b0;
      endcase
   end

   assign PCSrc         = Branch_in & cond_c;
   assign Flush         = PCSrc;
   assign Branch_target = PCplusimm_in;

   // Access FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Access FSM next state, stall and completion strobe
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      Stall      = 1'b0;
      complete_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (MemRead_in || MemWrite_in) begin
               if (MEM_LAT > 1) begin
                  Stall   = 1'b1;
                  state_d = ACCESS;
                  cnt_d   = 3'd1;
               end else begin
                  complete_c = 1'b1;
               end
            end
         end
         ACCESS: begin
            if (cnt_q < LAST_CNT) begin
               Stall = 1'b1;
               cnt_d = cnt_q + 3'd1;
            end else begin
               complete_c = 1'b1;
               state_d    = IDLE;
               cnt_d      = 3'd0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   // Access size in bytes from funct3[1:0]
   always_comb begin
      nbytes_c = 4'd1;
      case (funct3[1:0])
         2'b00:   nbytes_c = 4'd1;
         2'b01:   nbytes_c = 4'd2;
         2'b10:   nbytes_c = 4'd4;
         default: nbytes_c = 4'd8;
      endcase
   end

   assign store_en_c = complete_c & MemWrite_in & ~funct3[2];

   // Store commit at the edge ending the completion cycle; addresses wrap
   always_ff @(posedge clk) begin
      if (!reset && store_en_c) begin
         for (int unsigned i = 0; i < 8; i++) begin
            if (4'(i) < nbytes_c) begin
               mem_q[addr_c + ADDR_W'(i)] <= WriteData_in[8*i +: 8];
            end
         end
      end
   end

   // Little-endian gather of 8 bytes starting at the access address
   always_comb begin
      raw_c = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         raw_c[8*i +: 8] = mem_q[addr_c + ADDR_W'(i)];
      end
   end

   // Load extension; zero unless a pure load completes this cycle
   always_comb begin
      load_c = '0;
      if (complete_c && MemRead_in && !MemWrite_in) begin
         case (funct3)
            3'b000:  load_c = {{56{raw_c[7]}},  raw_c[7:0]};
            3'b001:  load_c = {{48{raw_c[15]}}, raw_c[15:0]};
            3'b010:  load_c = {{32{raw_c[31]}}, raw_c[31:0]};
            3'b011:  load_c = raw_c;
            3'b100:  load_c = {56'd0, raw_c[7:0]};
            3'b101:  load_c = {48'd0, raw_c[15:0]};
            3'b110:  load_c = {32'd0, raw_c[31:0]};
            default: load_c = '0;
         endcase
      end
   end

   // MEM/WB register; bubbles inserted while stalled
   always_ff @(posedge clk) begin
      if (reset) begin
         regwrite_q  <= 1'b0;
         memtoreg_q  <= 1'b0;
         readdata_q  <= '0;
         aluresult_q <= '0;
         rd_q        <= '0;
      end else if (Stall) begin
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         rd_q       <= '0;
      end else begin
         regwrite_q  <= RegWrite_in;
         memtoreg_q  <= MemtoReg_in;
         readdata_q  <= load_c;
         aluresult_q <= ALU_result_in;
         rd_q        <= rd_in;
      end
   end

   assign RegWrite_wb   = regwrite_q;
   assign MemtoReg_wb   = memtoreg_q;
   assign ReadData_wb   = readdata_q;
   assign ALU_result_wb = aluresult_q;
   assign rd_wb         = rd_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: one instance with single-cycle memory, one with
// three-cycle memory, each exercised while the other is held in reset.
module tb_mem_wb_stage;

   localparam int unsigned MB = 1024;
   localparam int unsigned AW = 10;

   logic        clk;
   logic        rst1, rst3;
   logic        RegWrite_in, MemtoReg_in, Branch_in, Zero_in, Is_Greater_in;
   logic        MemWrite_in, MemRead_in;
   logic [63:0] PCplusimm_in, ALU_result_in, WriteData_in;
   logic [3:0]  funct_in;
   logic [4:0]  rd_in;

   logic        pcsrc1, flush1, stall1, rw1, m2r1;
   logic [63:0] tgt1, rdat1, alu1;
   logic [4:0]  rd1;
   logic        pcsrc3, flush3, stall3, rw3, m2r3;
   logic [63:0] tgt3, rdat3, alu3;
   logic [4:0]  rd3;

   logic        sel3;
   logic        o_pcsrc, o_flush, o_stall, o_rw, o_m2r;
   logic [63:0] o_tgt, o_rdat, o_alu;
   logic [4:0]  o_rd;

   logic [7:0]  mem_m [MB];
   logic [63:0] exp_alu, exp_rdat;
   int          n_vec, n_err;

   mem_wb_stage #(.MEM_BYTES(MB), .ADDR_W(AW), .MEM_LAT(1)) u_lat1 (
      .clk(clk), .reset(rst1),
      .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .Branch_in(Branch_in),
      .Zero_in(Zero_in), .Is_Greater_in(Is_Greater_in), .MemWrite_in(MemWrite_in),
      .MemRead_in(MemRead_in), .PCplusimm_in(PCplusimm_in), .ALU_result_in(ALU_result_in),
      .WriteData_in(WriteData_in), .funct_in(funct_in), .rd_in(rd_in),
      .PCSrc(pcsrc1), .Branch_target(tgt1), .Flush(flush1), .Stall(stall1),
      .RegWrite_wb(rw1), .MemtoReg_wb(m2r1), .ReadData_wb(rdat1),
      .ALU_result_wb(alu1), .rd_wb(rd1)
   );

   mem_wb_stage #(.MEM_BYTES(MB), .ADDR_W(AW), .MEM_LAT(3)) u_lat3 (
      .clk(clk), .reset(rst3),
      .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .Branch_in(Branch_in),
      .Zero_in(Zero_in), .Is_Greater_in(Is_Greater_in), .MemWrite_in(MemWrite_in),
      .MemRead_in(MemRead_in), .PCplusimm_in(PCplusimm_in), .ALU_result_in(ALU_result_in),
      .WriteData_in(WriteData_in), .funct_in(funct_in), .rd_in(rd_in),
      .PCSrc(pcsrc3), .Branch_target(tgt3), .Flush(flush3), .Stall(stall3),
      .RegWrite_wb(rw3), .MemtoReg_wb(m2r3), .ReadData_wb(rdat3),
      .ALU_result_wb(alu3), .rd_wb(rd3)
   );

   assign o_pcsrc = sel3 ? pcsrc3 : pcsrc1;
   assign o_flush = sel3 ? flush3 : flush1;
   assign o_stall = sel3 ? stall3 : stall1;
   assign o_rw    = sel3 ? rw3    : rw1;
   assign o_m2r   = sel3 ? m2r3   : m2r1;
   assign o_tgt   = sel3 ? tgt3   : tgt1;
   assign o_rdat  = sel3 ? rdat3  : rdat1;
   assign o_alu   = sel3 ? alu3   : alu1;
   assign o_rd    = sel3 ? rd3    : rd1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic bcond(input logic [2:0] f3, input logic z, input logic g);
      case (f3)
         3'd0:    return z;
         3'd1:    return !z;
         3'd4:    return !g && !z;
         3'd5:    return g || z;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [63:0] m_load(input logic [63:0] a, input logic [2:0] f3);
      int unsigned base, n;
      logic [63:0] v;
      if (f3 == 3'd7) return 64'd0;
      base = 32'(a % 64'(MB));
      n    = 1 << f3[1:0];
      v    = 64'd0;
      for (int unsigned i = 0; i < n; i++)
         v = v | (64'(mem_m[(base + i) % MB]) << (8 * i));
      if (!f3[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
      return v;
   endfunction

   task automatic m_store(input logic [63:0] a, input logic [2:0] f3, input logic [63:0] d);
      int unsigned base, n;
      base = 32'(a % 64'(MB));
      n    = f3[2] ? 0 : (1 << f3[1:0]);
      for (int unsigned i = 0; i < n; i++)
         mem_m[(base + i) % MB] = 8'(d >> (8 * i));
   endtask

   task automatic drive_idle();
      RegWrite_in = 0; MemtoReg_in = 0; Branch_in = 0; Zero_in = 0; Is_Greater_in = 0;
      MemWrite_in = 0; MemRead_in = 0; PCplusimm_in = 0; ALU_result_in = 0;
      WriteData_in = 0; funct_in = 0; rd_in = 0;
   endtask

   task automatic chk_wb_zero(input string tag);
      chk({tag, "_rw"},   64'(o_rw), 64'd0);
      chk({tag, "_m2r"},  64'(o_m2r), 64'd0);
      chk({tag, "_rdat"}, o_rdat, 64'd0);
      chk({tag, "_alu"},  o_alu, 64'd0);
      chk({tag, "_rd"},   64'(o_rd), 64'd0);
   endtask

   // Apply one instruction for its full occupancy and check every cycle
   task automatic do_op(input logic rw, input logic m2r, input logic br, input logic z,
                        input logic g, input logic mw, input logic mr,
                        input logic [63:0] pci, input logic [63:0] alu,
                        input logic [63:0] wd, input logic [3:0] f, input logic [4:0] rd);
      int cyc;
      logic pc_exp;
      logic [63:0] rdat;
      RegWrite_in = rw; MemtoReg_in = m2r; Branch_in = br; Zero_in = z; Is_Greater_in = g;
      MemWrite_in = mw; MemRead_in = mr; PCplusimm_in = pci; ALU_result_in = alu;
      WriteData_in = wd; funct_in = f; rd_in = rd;
      cyc    = (mw || mr) ? (sel3 ? 3 : 1) : 1;
      pc_exp = br & bcond(f[2:0], z, g);
      rdat   = 64'd0;
      for (int c = 0; c < cyc; c++) begin
         @(negedge clk);
         chk("pcsrc",  64'(o_pcsrc), 64'(pc_exp));
         chk("flush",  64'(o_flush), 64'(pc_exp));
         chk("target", o_tgt, pci);
         chk("stall",  64'(o_stall), 64'(c < cyc - 1));
         if (c == cyc - 1) begin
            rdat = (mr && !mw) ? m_load(alu, f[2:0]) : 64'd0;
            if (mw) m_store(alu, f[2:0], wd);
         end
         @(posedge clk); #1;
         if (c < cyc - 1) begin
            chk("bub_rw",   64'(o_rw), 64'd0);
            chk("bub_m2r",  64'(o_m2r), 64'd0);
            chk("bub_rd",   64'(o_rd), 64'd0);
            chk("bub_alu",  o_alu, exp_alu);
            chk("bub_rdat", o_rdat, exp_rdat);
         end else begin
            exp_alu  = alu;
            exp_rdat = rdat;
            chk("wb_rw",   64'(o_rw), 64'(rw));
            chk("wb_m2r",  64'(o_m2r), 64'(m2r));
            chk("wb_rd",   64'(o_rd), 64'(rd));
            chk("wb_alu",  o_alu, exp_alu);
            chk("wb_rdat", o_rdat, exp_rdat);
         end
      end
   endtask

   task automatic start_phase(input logic use3);
      drive_idle();
      sel3 = use3;
      rst1 = 1'b1;
      rst3 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_wb_zero("reset");
      if (use3) rst3 = 1'b0; else rst1 = 1'b0;
      exp_alu  = 64'd0;
      exp_rdat = 64'd0;
      for (int unsigned i = 0; i < MB; i++) mem_m[i] = 8'd0;
      // Bring the whole DUT memory to a known zero state
      for (int unsigned a = 0; a < MB; a += 8)
         do_op(0, 0, 0, 0, 0, 1, 0, 64'd0, 64'(a), 64'd0, 4'd3, 5'd0);
   endtask

   task automatic random_ops(input int n);
      logic [63:0] a;
      logic [3:0]  f;
      int kind;
      for (int k = 0; k < n; k++) begin
         a = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) a[AW-1:0] = AW'(MB - $urandom_range(1, 7));
         f    = 4'($urandom_range(0, 15));
         kind = $urandom_range(0, 3);
         case (kind)
            0: do_op(1'($urandom), 1'($urandom), 0, 1'($urandom), 1'($urandom), 0, 1,
                     {$urandom, $urandom}, a, {$urandom, $urandom}, f, 5'($urandom));
            1: do_op(1'($urandom), 1'($urandom), 0, 1'($urandom), 1'($urandom), 1, 0,
                     {$urandom, $urandom}, a, {$urandom, $urandom}, f, 5'($urandom));
            2: do_op(1'($urandom), 0, 1, 1'($urandom), 1'($urandom), 0, 0,
                     {$urandom, $urandom}, a, {$urandom, $urandom}, f, 5'($urandom));
            default: do_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom), 1'($urandom),
                     {$urandom, $urandom}, a, {$urandom, $urandom}, f, 5'($urandom));
         endcase
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst1  = 1'b1;
      rst3  = 1'b1;
      sel3  = 1'b0;
      drive_idle();
      @(posedge clk); #1;

      // Single-cycle memory
      start_phase(1'b0);
      do_op(0, 0, 0, 0, 0, 1, 0, 64'd0, 64'h10, 64'h1122334455667788, 4'd3, 5'd0);
      do_op(1, 1, 0, 0, 0, 0, 1, 64'd0, 64'h10, 64'd0, 4'd3, 5'd7);
      chk("tp1_ld", o_rdat, 64'h1122334455667788);
      do_op(0, 0, 0, 0, 0, 1, 0, 64'd0, 64'h3, 64'h80, 4'd0, 5'd0);
      do_op(1, 1, 0, 0, 0, 0, 1, 64'd0, 64'h3, 64'd0, 4'd0, 5'd1);
      chk("tp2_lb", o_rdat, 64'hFFFFFFFFFFFFFF80);
      do_op(1, 1, 0, 0, 0, 0, 1, 64'd0, 64'h3, 64'd0, 4'd4, 5'd2);
      chk("tp2_lbu", o_rdat, 64'h0000000000000080);
      do_op(1, 1, 0, 0, 0, 0, 1, 64'd0, 64'h0, 64'd0, 4'd2, 5'd3);
      chk("tp2_lw", o_rdat, 64'hFFFFFFFF80000000);
      do_op(0, 0, 1, 1, 0, 0, 0, 64'h40, 64'd0, 64'd0, 4'd0, 5'd0);
      do_op(0, 0, 1, 0, 0, 0, 0, 64'h40, 64'd0, 64'd0, 4'd5, 5'd0);
      do_op(0, 0, 0, 0, 0, 1, 0, 64'd0, 64'(MB - 4), 64'h0123456789ABCDEF, 4'd3, 5'd0);
      do_op(1, 1, 0, 0, 0, 0, 1, 64'd0, 64'h0, 64'd0, 4'd3, 5'd4);
      chk("tp6_wrap", o_rdat & 64'hFFFFFFFF, 64'h01234567);
      random_ops(150);

      // Three-cycle memory
      start_phase(1'b1);
      RegWrite_in = 0; MemWrite_in = 1; MemRead_in = 0; funct_in = 4'd3;
      ALU_result_in = 64'h20; WriteData_in = 64'hAAAAAAAAAAAAAAAA;
      @(negedge clk);
      chk("tp5_stall", 64'(o_stall), 64'd1);
      @(posedge clk); #1;
      rst3 = 1'b1;
      @(posedge clk); #1;
      rst3 = 1'b0;
      drive_idle();
      chk_wb_zero("tp5_rst");
      exp_alu  = 64'd0;
      exp_rdat = 64'd0;
      do_op(1, 1, 0, 0, 0, 0, 1, 64'd0, 64'h20, 64'd0, 4'd3, 5'd6);
      chk("tp5_old", o_rdat, 64'd0);
      do_op(0, 0, 0, 0, 0, 1, 0, 64'd0, 64'h30, 64'hDEADBEEFCAFEF00D, 4'd3, 5'd0);
      do_op(1, 1, 0, 0, 0, 0, 1, 64'd0, 64'h30, 64'd0, 4'd3, 5'd5);
      chk("tp4_ld", o_rdat, 64'hDEADBEEFCAFEF00D);
      random_ops(150);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Memory stage of the 5-stage 64-bit RISC-V pipeline, directly downstream of the EX/MEM register.
- Resolves conditional branches and drives the PC-select and flush signals back to IF/ID/EX/MEM.
- Performs loads and stores on a byte-addressed data memory with a configurable access latency, stalling upstream while an access is in progress.
- Registers the results into MEM/WB outputs for write-back.

Parameters:
MEM_BYTES, 1024, data memory size in bytes (power of two).
ADDR_W, 10, log2(MEM_BYTES); address bits taken from ALU_result_in.
MEM_LAT, 1, total cycles per load/store access (1..8); 1 means no stall.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
RegWrite_in  in  1  from EX/MEM.
MemtoReg_in  in  1  from EX/MEM.
Branch_in  in  1  from EX/MEM.
Zero_in  in  1  ALU result == 0.
Is_Greater_in  in  1  ALU signed rs1 > rs2.
MemWrite_in  in  1  store request.
MemRead_in  in  1  load request.
PCplusimm_in  in  64  branch target.
ALU_result_in  in  64  address or ALU value.
WriteData_in  in  64  store data (rs2).
funct_in  in  4  {funct7[5], funct3}; only funct3 = funct_in[2:0] is used here.
rd_in  in  5  destination register.
PCSrc  out  1  take branch (combinational).
Branch_target  out  64  equals PCplusimm_in.
Flush  out  1  equals PCSrc; clears IF/ID, ID/EX, EX/MEM.
Stall  out  1  upstream must hold PC and all pipeline registers (combinational).
RegWrite_wb  out  1  MEM/WB register.
MemtoReg_wb  out  1  MEM/WB register.
ReadData_wb  out  64  MEM/WB register.
ALU_result_wb  out  64  MEM/WB register.
rd_wb  out  5  MEM/WB register.

Behaviour:
Clock and reset (already decided):
- One clock, clk.
- Reset is synchronous and active-high, port reset.
- On reset: all *_wb outputs = 0, FSM = IDLE, latency counter = 0.
- Memory contents are not cleared by reset; they are zero at time 0.

Branch resolution (funct3), PCSrc = Branch_in & cond, independent of memory FSM:
- 000 beq: Zero_in.
- 001 bne: !Zero_in.
- 100 blt: !Is_Greater_in & !Zero_in.
- 101 bge: Is_Greater_in | Zero_in.
- Any other funct3: cond = 0.

Memory addressing:
- Address = ALU_result_in[ADDR_W-1:0], little-endian.
- Multi-byte accesses wrap modulo MEM_BYTES.
- Misaligned accesses are allowed.

Loads (funct3):
- 000 lb, 001 lh, 010 lw: sign-extended.
- 011 ld: full 64 bits.
- 100 lbu, 101 lhu, 110 lwu: zero-extended.
- 111: result 0.

Stores (funct3): 000 sb, 001 sh, 010 sw, 011 sd, using the low bytes of WriteData_in. Other funct3: no write.

Simultaneous MemRead_in & MemWrite_in: the store executes, ReadData_wb = 0.

FSM, states IDLE and ACCESS, 3-bit counter cnt:
- IDLE, memory op present, MEM_LAT > 1: Stall = 1; next state ACCESS, cnt = 1.
- ACCESS, cnt < MEM_LAT-1: Stall = 1; cnt increments.
- ACCESS, cnt == MEM_LAT-1: Stall = 0 (completion cycle); next state IDLE.
- MEM_LAT == 1: every op completes in its IDLE cycle, Stall never asserts.
- Total occupancy is MEM_LAT cycles with Stall high for MEM_LAT-1 of them.
- Upstream guarantees the *_in signals are stable while Stall = 1.

Commit rules:
- A store commits exactly once, at the clock edge ending its completion cycle.
- Load data is read combinationally in the completion cycle and captured into ReadData_wb at that edge.

MEM/WB register update per edge:
- Stall = 1: insert bubble (RegWrite_wb = 0, MemtoReg_wb = 0, rd_wb = 0; data fields hold).
- Otherwise: RegWrite_wb <= RegWrite_in, MemtoReg_wb <= MemtoReg_in, ALU_result_wb <= ALU_result_in, rd_wb <= rd_in, ReadData_wb <= load result (0 if not a load).

Boundary cases:
- Reset during ACCESS: pending store discarded (no write), FSM to IDLE, outputs cleared.
- Branch instructions carry no memory op, so PCSrc and Stall are never asserted together by legal code; if they are, both outputs still follow their own rules.

Test Plan:
1. MEM_LAT=1; sd of 0x1122334455667788 at addr 0x10, then ld from 0x10 -> ReadData_wb = 0x1122334455667788 one edge after the load; Stall never high.
2. sb 0x80 at addr 0x3, then lb / lbu from 0x3 -> ReadData_wb = 0xFFFFFFFFFFFFFF80 / 0x0000000000000080; lw from 0x0 -> 0xFFFFFFFF80000000.
3. Branch_in=1, funct3=000, Zero_in=1, PCplusimm_in=0x40 -> PCSrc = Flush = 1, Branch_target = 0x40. Then funct3=101 with Is_Greater_in=0, Zero_in=0 -> PCSrc = 0.
4. MEM_LAT=3; ld with rd=5 -> Stall high 2 cycles with MEM/WB showing bubbles (RegWrite_wb=0); third edge gives rd_wb=5, RegWrite_wb=1 and the correct data.
5. MEM_LAT=3; sd 0xAA..AA issued, reset asserted in the second cycle -> afterwards ld returns the old contents (0), FSM is IDLE, all *_wb outputs are 0.
6. sd at addr MEM_BYTES-4 -> bytes 4..7 land at addresses 0..3 (wrap); ld from addr 0 returns the upper word in its low 32 bits.
